// File: rtl/control_pkg.sv
// Shared encodings for the control sequencer: states, register addresses,
// ALU operation codes, opcodes and the packed control word.
package control_pkg;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_HALT  = 4'd1,
    S_F0    = 4'd2,
    S_F1    = 4'd3,
    S_DEC   = 4'd4,
    S_EXA   = 4'd5,
    S_LD0   = 4'd6,
    S_LD1   = 4'd7,
    S_LD2   = 4'd8,
    S_ST0   = 4'd9,
    S_ST1   = 4'd10,
    S_ST2   = 4'd11,
    S_BR    = 4'd12
  } state_e;

  // Register bank addresses
  localparam logic [2:0] REG_PC   = 3'b000;
  localparam logic [2:0] REG_DPTR = 3'b001;
  localparam logic [2:0] REG_A    = 3'b011;
  localparam logic [2:0] REG_TEMP = 3'b100;
  localparam logic [2:0] REG_ACC  = 3'b111;

  // ALU operation codes
  localparam logic [2:0] SEL_PASS = 3'b000;
  localparam logic [2:0] SEL_INC  = 3'b001;
  localparam logic [2:0] SEL_ADD  = 3'b010;
  localparam logic [2:0] SEL_AND  = 3'b011;
  localparam logic [2:0] SEL_XOR  = 3'b100;
  localparam logic [2:0] SEL_OR   = 3'b101;
  localparam logic [2:0] SEL_SHL  = 3'b110;
  localparam logic [2:0] SEL_SHR  = 3'b111;

  // Opcodes outside the ALU/shift classes
  localparam logic [4:0] OP_LOAD  = 5'b10000;
  localparam logic [4:0] OP_STORE = 5'b10001;
  localparam logic [4:0] OP_JMP   = 5'b11000;
  localparam logic [4:0] OP_JZ    = 5'b11001;
  localparam logic [4:0] OP_JN    = 5'b11010;
  localparam logic [4:0] OP_JC    = 5'b11011;
  localparam logic [4:0] OP_JP    = 5'b11100;
  localparam logic [4:0] OP_HALT  = 5'b11111;

  // Everything memory_system needs from us in one cycle
  typedef struct packed {
    logic       ir_sclr;
    logic       mar_sclr;
    logic       enaf;
    logic [2:0] selop;
    logic [1:0] shamt;
    logic       bank_wr_en;
    logic [2:0] busB_addr;
    logic [2:0] busC_addr;
    logic       ir_en;
    logic       mar_en;
    logic       mdr_en;
    logic       wr_rdn;
    logic       mdr_alu_n;
    logic       halted;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // All strobes inactive
  function automatic ctrl_t ctrl_idle();
    return ctrl_t'({CTRL_W{1'b0}});
  endfunction

  // Word held while the sequencer sits in RESET: clear IR and MAR only
  function automatic ctrl_t ctrl_reset();
    ctrl_t c;
    c          = ctrl_idle();
    c.ir_sclr  = 1'b1;
    c.mar_sclr = 1'b1;
    return c;
  endfunction

  // Branch resolution against the flags present during DEC
  function automatic logic branch_taken(input logic [4:0] instr,
                                        input logic c, input logic n,
                                        input logic p, input logic z);
    logic t;
    case (instr)
      OP_JMP:  t = 1'b1;
      OP_JZ:   t = z;
      OP_JN:   t = n;
      OP_JC:   t = c;
      OP_JP:   t = p;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control/status bundle between the sequencer (master) and memory_system (slave).
interface control_sequencer_if;
  logic       run;
  logic [4:0] instruction;
  logic       C;
  logic       N;
  logic       P;
  logic       Z;
  logic       ir_sclr;
  logic       mar_sclr;
  logic       enaf;
  logic [2:0] selop;
  logic [1:0] shamt;
  logic       bank_wr_en;
  logic [2:0] busB_addr;
  logic [2:0] busC_addr;
  logic       ir_en;
  logic       mar_en;
  logic       mdr_en;
  logic       wr_rdn;
  logic       mdr_alu_n;
  logic       halted;
  logic [3:0] state_m;

  modport master (
    input  run, instruction, C, N, P, Z,
    output ir_sclr, mar_sclr, enaf, selop, shamt, bank_wr_en, busB_addr,
           busC_addr, ir_en, mar_en, mdr_en, wr_rdn, mdr_alu_n, halted, state_m
  );

  modport slave (
    output run, instruction, C, N, P, Z,
    input  ir_sclr, mar_sclr, enaf, selop, shamt, bank_wr_en, busB_addr,
           busC_addr, ir_en, mar_en, mdr_en, wr_rdn, mdr_alu_n, halted, state_m
  );
endinterface

// File: rtl/control_decoder.sv
// Combinational microcode ROM: control word for the state about to be entered.
module control_decoder
  import control_pkg::*;
(
  input  state_e     i_state,
  input  logic [4:0] i_instr,
  output ctrl_t      o_ctrl
);

  // Decode the control word of the incoming state
  always_comb begin
    o_ctrl = ctrl_idle();
    case (i_state)
      S_RESET: o_ctrl = ctrl_reset();
      S_HALT:  o_ctrl.halted = 1'b1;
      S_F0: begin
        o_ctrl.busB_addr = REG_PC;
        o_ctrl.selop     = SEL_PASS;
        o_ctrl.mar_en    = 1'b1;
      end
      S_F1: begin
        o_ctrl.ir_en      = 1'b1;
        o_ctrl.busB_addr  = REG_PC;
        o_ctrl.busC_addr  = REG_PC;
        o_ctrl.selop      = SEL_INC;
        o_ctrl.bank_wr_en = 1'b1;
      end
      S_DEC: o_ctrl = ctrl_idle();
      S_EXA: begin
        o_ctrl.busB_addr  = REG_A;
        o_ctrl.busC_addr  = REG_ACC;
        o_ctrl.enaf       = 1'b1;
        o_ctrl.bank_wr_en = 1'b1;
        // Shift class carries direction in bit 2 and amount in bits 1:0
        if (i_instr[4:3] == 2'b01) begin
          o_ctrl.selop = i_instr[2] ? SEL_SHR : SEL_SHL;
          o_ctrl.shamt = i_instr[1:0];
        end else begin
          o_ctrl.selop = i_instr[2:0];
          o_ctrl.shamt = 2'b00;
        end
      end
      S_LD0, S_ST0: begin
        o_ctrl.busB_addr = REG_DPTR;
        o_ctrl.selop     = SEL_PASS;
        o_ctrl.mar_en    = 1'b1;
      end
      S_LD1: begin
        o_ctrl.mdr_alu_n = 1'b1;
        o_ctrl.mdr_en    = 1'b1;
      end
      S_LD2: begin
        o_ctrl.mdr_alu_n  = 1'b1;
        o_ctrl.busC_addr  = REG_ACC;
        o_ctrl.bank_wr_en = 1'b1;
      end
      S_ST1: begin
        o_ctrl.busB_addr = REG_ACC;
        o_ctrl.selop     = SEL_PASS;
        o_ctrl.mdr_en    = 1'b1;
      end
      S_ST2: o_ctrl.wr_rdn = 1'b1;
      S_BR: begin
        o_ctrl.busB_addr  = REG_DPTR;
        o_ctrl.selop      = SEL_PASS;
        o_ctrl.busC_addr  = REG_PC;
        o_ctrl.bank_wr_en = 1'b1;
      end
      default: o_ctrl = ctrl_reset();
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded fetch/decode/execute sequencer driving memory_system.
// Outputs are registered from the decode of the next state, so every
// strobe lines up with the state shown on state_m.
module control_sequencer
  import control_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 2
)
(
  input logic                 clk,
  input logic                 rst,
  control_sequencer_if.master ctl
);

  localparam logic [3:0] RESET_LAST = 4'(RESET_CYCLES - 1);

  state_e     r_state;
  state_e     w_next;
  logic [3:0] r_cnt;
  ctrl_t      w_ctrl;
  ctrl_t      r_ctrl;
  logic       w_taken;

  assign w_taken = branch_taken(ctl.instruction, ctl.C, ctl.N, ctl.P, ctl.Z);

  // Next-state selection; reset and unused encodings both lead to RESET
  always_comb begin
    w_next = S_RESET;
    if (rst) begin
      w_next = S_RESET;
    end else begin
      case (r_state)
        S_RESET: begin
          if (r_cnt >= RESET_LAST) w_next = S_HALT;
          else                     w_next = S_RESET;
        end
        S_HALT: begin
          if (ctl.run) w_next = S_F0;
          else         w_next = S_HALT;
        end
        S_F0:  w_next = S_F1;
        S_F1:  w_next = S_DEC;
        S_DEC: begin
          if (ctl.instruction[4] == 1'b0)         w_next = S_EXA;
          else if (ctl.instruction == OP_LOAD)    w_next = S_LD0;
          else if (ctl.instruction == OP_STORE)   w_next = S_ST0;
          else if (ctl.instruction == OP_HALT)    w_next = S_HALT;
          else if (w_taken)                       w_next = S_BR;
          else                                    w_next = S_F0;
        end
        S_LD0: w_next = S_LD1;
        S_LD1: w_next = S_LD2;
        S_ST0: w_next = S_ST1;
        S_ST1: w_next = S_ST2;
        S_EXA, S_LD2, S_ST2, S_BR: w_next = S_F0;
        default: w_next = S_RESET;
      endcase
    end
  end

  control_decoder u_decoder (
    .i_state (w_next),
    .i_instr (ctl.instruction),
    .o_ctrl  (w_ctrl)
  );

  // State register, RESET hold counter and registered control word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RESET;
      r_cnt   <= 4'd0;
      r_ctrl  <= ctrl_reset();
    end else begin
      r_state <= w_next;
      r_ctrl  <= w_ctrl;
      if (r_state == S_RESET && w_next == S_RESET) r_cnt <= r_cnt + 4'd1;
      else                                         r_cnt <= 4'd0;
    end
  end

  assign ctl.ir_sclr    = r_ctrl.ir_sclr;
  assign ctl.mar_sclr   = r_ctrl.mar_sclr;
  assign ctl.enaf       = r_ctrl.enaf;
  assign ctl.selop      = r_ctrl.selop;
  assign ctl.shamt      = r_ctrl.shamt;
  assign ctl.bank_wr_en = r_ctrl.bank_wr_en;
  assign ctl.busB_addr  = r_ctrl.busB_addr;
  assign ctl.busC_addr  = r_ctrl.busC_addr;
  assign ctl.ir_en      = r_ctrl.ir_en;
  assign ctl.mar_en     = r_ctrl.mar_en;
  assign ctl.mdr_en     = r_ctrl.mdr_en;
  assign ctl.wr_rdn     = r_ctrl.wr_rdn;
  assign ctl.mdr_alu_n  = r_ctrl.mdr_alu_n;
  assign ctl.halted     = r_ctrl.halted;
  assign ctl.state_m    = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a queue-based instruction-level model predicts
// the state and control word every cycle; directed literal checks pin the model.
module tb_control_sequencer;
  import control_pkg::*;

  localparam int RC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_sequencer_if bus ();

  control_sequencer #(.RESET_CYCLES(RC)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: current state number, queue of states already decided for coming cycles
  int         ms = 0;
  int         q[$];
  logic [4:0] ex_instr = 5'd0;
  bit         mv = 1'b0;
  bit         inject = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Control word each state must show, straight from the state table
  function automatic logic [24:0] exp_word(input int s, input logic [4:0] ins);
    logic isc, msc, enf, bw, ire, mare, mdre, wr, ma, hl;
    logic [2:0] sel, bb, bc;
    logic [1:0] sh;
    {isc, msc, enf, bw, ire, mare, mdre, wr, ma, hl} = 10'd0;
    sel = 3'd0; bb = 3'd0; bc = 3'd0; sh = 2'd0;
    case (s)
      0:  begin isc = 1'b1; msc = 1'b1; end
      1:  hl = 1'b1;
      2:  begin bb = 3'b000; sel = 3'b000; mare = 1'b1; end
      3:  begin ire = 1'b1; bb = 3'b000; bc = 3'b000; sel = 3'b001; bw = 1'b1; end
      5:  begin
            bb = 3'b011; bc = 3'b111; enf = 1'b1; bw = 1'b1;
            if (ins[3]) begin sel = ins[2] ? 3'b111 : 3'b110; sh = ins[1:0]; end
            else        sel = ins[2:0];
          end
      6, 9: begin bb = 3'b001; sel = 3'b000; mare = 1'b1; end
      7:  begin ma = 1'b1; mdre = 1'b1; end
      8:  begin ma = 1'b1; bc = 3'b111; bw = 1'b1; end
      10: begin bb = 3'b111; sel = 3'b000; mdre = 1'b1; end
      11: wr = 1'b1;
      12: begin bb = 3'b001; sel = 3'b000; bc = 3'b000; bw = 1'b1; end
      default: ;
    endcase
    return {isc, msc, enf, sel, sh, bw, bb, bc, ire, mare, mdre, wr, ma, hl, 4'(s)};
  endfunction

  function automatic logic [24:0] dut_word();
    return {bus.ir_sclr, bus.mar_sclr, bus.enaf, bus.selop, bus.shamt, bus.bank_wr_en,
            bus.busB_addr, bus.busC_addr, bus.ir_en, bus.mar_en, bus.mdr_en,
            bus.wr_rdn, bus.mdr_alu_n, bus.halted, bus.state_m};
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    logic [4:0] ins;
    ins = bus.instruction;
    if (rst || inject) begin
      ms = 0;
      q.delete();
      repeat (RC - 1) q.push_back(0);
      q.push_back(1);
      if (rst) mv = 1'b1;
    end else if (mv) begin
      if (ms == 4) begin
        ex_instr = ins;
        if (ins[4] == 1'b0) q.push_back(5);
        else if (ins == 5'b10000) begin q.push_back(6); q.push_back(7); q.push_back(8); end
        else if (ins == 5'b10001) begin q.push_back(9); q.push_back(10); q.push_back(11); end
        else if (ins == 5'b11111) q.push_back(1);
        else if (ins == 5'b11000 || (ins == 5'b11001 && bus.Z) || (ins == 5'b11010 && bus.N) ||
                 (ins == 5'b11011 && bus.C) || (ins == 5'b11100 && bus.P))
          q.push_back(12);
      end
      if (q.size() > 0)  ms = q.pop_front();
      else if (ms == 1)  ms = bus.run ? 2 : 1;
      else               ms = 2;
      if (ms == 2) begin q.push_back(3); q.push_back(4); end
    end
  endtask

  // One clock: model update at the edge, full compare shortly after, return at negedge
  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
    if (mv) check("cycle_word", 32'(dut_word()), 32'(exp_word(ms, ex_instr)));
    @(negedge clk);
  endtask

  logic [4:0] codes [10] = '{5'b00100, 5'b00010, 5'b01110, 5'b01001, 5'b10000,
                             5'b10001, 5'b11000, 5'b11001, 5'b11100, 5'b11111};

  initial begin
    rst = 1'b1; bus.run = 1'b0; bus.instruction = 5'd0;
    bus.C = 1'b0; bus.N = 1'b0; bus.P = 1'b0; bus.Z = 1'b0;
    @(negedge clk);
    tick(); tick();
    check("rst_state", 32'(bus.state_m), 32'd0);
    check("rst_sclr", 32'({bus.ir_sclr, bus.mar_sclr}), 32'd3);

    // Two RESET cycles after release, then HALT
    rst = 1'b0;
    check("hold1_sclr", 32'({bus.ir_sclr, bus.mar_sclr}), 32'd3);
    tick();
    check("hold2_sclr", 32'({bus.ir_sclr, bus.mar_sclr}), 32'd3);
    tick();
    check("halt_state", 32'(bus.state_m), 32'd1);
    check("halt_flag", 32'(bus.halted), 32'd1);

    // XOR: 2,3,4,5 then 2
    bus.run = 1'b1; bus.instruction = 5'b00100;
    tick(); check("run_f0", 32'(bus.state_m), 32'd2);
    bus.run = 1'b0;
    tick(); check("xor_f1", 32'(bus.state_m), 32'd3);
    tick(); check("xor_dec", 32'(bus.state_m), 32'd4);
    tick(); check("xor_exa", 32'(bus.state_m), 32'd5);
    check("xor_selop", 32'(bus.selop), 32'h4);
    check("xor_busB", 32'(bus.busB_addr), 32'h3);
    check("xor_busC", 32'(bus.busC_addr), 32'h7);
    check("xor_enaf_wr", 32'({bus.enaf, bus.bank_wr_en}), 32'd3);
    tick(); check("xor_back_f0", 32'(bus.state_m), 32'd2);

    // Shift right by 2
    bus.instruction = 5'b01110;
    tick(); tick(); tick();
    check("shr_selop", 32'(bus.selop), 32'h7);
    check("shr_shamt", 32'(bus.shamt), 32'h2);
    tick();

    // STORE
    bus.instruction = 5'b10001;
    tick(); tick(); tick(); tick();
    check("st1_state", 32'(bus.state_m), 32'd10);
    check("st1_src", 32'({bus.mdr_alu_n, bus.mdr_en, bus.busB_addr}), 32'({1'b0, 1'b1, 3'b111}));
    tick();
    check("st2_wr", 32'({bus.wr_rdn, bus.mdr_en}), 32'd2);
    tick();

    // JZ not taken, then taken
    bus.instruction = 5'b11001; bus.Z = 1'b0;
    tick(); tick(); tick();
    check("jz_nt", 32'(bus.state_m), 32'd2);
    bus.Z = 1'b1;
    tick(); tick(); tick();
    check("jz_br", 32'(bus.state_m), 32'd12);
    check("br_ctrl", 32'({bus.busB_addr, bus.busC_addr, bus.bank_wr_en}), 32'({3'b001, 3'b000, 1'b1}));
    bus.Z = 1'b0;
    tick();

    // LOAD aborted by reset in LD1
    bus.instruction = 5'b10000;
    tick(); tick(); tick(); tick();
    check("ld1_mdr", 32'({bus.state_m, bus.mdr_en, bus.mdr_alu_n}), 32'({4'd7, 1'b1, 1'b1}));
    rst = 1'b1;
    tick();
    check("abort_state", 32'(bus.state_m), 32'd0);
    check("abort_strobes", 32'({bus.mdr_en, bus.wr_rdn, bus.ir_sclr}), 32'd1);
    rst = 1'b0;
    tick(); tick();
    check("abort_halt", 32'(bus.state_m), 32'd1);

    // HALT instruction, then restart
    bus.instruction = 5'b11111; bus.run = 1'b1;
    tick(); bus.run = 1'b0;
    tick(); tick(); tick();
    check("hlt_state", 32'({bus.state_m, bus.halted}), 32'({4'd1, 1'b1}));
    tick();
    check("hlt_stay", 32'(bus.state_m), 32'd1);
    bus.run = 1'b1;
    tick();
    check("hlt_restart", 32'(bus.state_m), 32'd2);
    bus.run = 1'b0;

    // Unused state encoding recovers through RESET
    force dut.r_state = state_e'(4'd13);
    #1;
    release dut.r_state;
    inject = 1'b1;
    tick();
    inject = 1'b0;
    check("illegal_reset", 32'({bus.state_m, bus.ir_sclr}), 32'({4'd0, 1'b1}));
    tick(); tick();
    check("illegal_halt", 32'(bus.state_m), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst     = ($urandom_range(0, 79) == 0);
      bus.run = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) bus.instruction = 5'($urandom_range(0, 31));
      else                           bus.instruction = codes[$urandom_range(0, 9)];
      {bus.C, bus.N, bus.P, bus.Z} = 4'($urandom_range(0, 15));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Microcoded control FSM that sits directly upstream of memory_system.
- Consumes the 5-bit instruction and the C/N/P/Z flags.
- Drives every memory_system control input: sclr, ALU select, bank addressing, IR/MAR/MDR enables, memory read/write.
- Sequences fetch, decode and execute for ALU, shift, load/store and branch instructions, plus a run/halt handshake.

Parameters:
RESET_CYCLES, 2, cycles the RESET state holds ir_sclr/mar_sclr after rst falls (1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
run  input  1  start request, sampled in HALT
instruction  input  5  IR contents from memory_system
C, N, P, Z  input  1 each  ALU flags from memory_system
ir_sclr, mar_sclr  output  1  synchronous clears of IR/MAR
enaf  output  1  flag update enable
selop  output  3  ALU operation
shamt  output  2  shift amount
bank_wr_en  output  1  register bank write
busB_addr, busC_addr  output  3  bank read/write addresses
ir_en, mar_en, mdr_en  output  1  register load enables
wr_rdn  output  1  1 = memory write, 0 = read
mdr_alu_n  output  1  1 = MDR/bus C from memory, 0 = from ALU
halted  output  1  high in HALT state
state_m  output  4  current state encoding (monitor)

Behaviour:
- All outputs are flops loaded with the decode of the next state, so they always match the current state.
- Any output not listed for a state is 0.
- Synchronous reset: at the first clk edge with rst=1, state becomes RESET, the counter clears, and outputs take RESET values (ir_sclr=1, mar_sclr=1, all else 0).
- Reset mid-operation aborts immediately; wr_rdn and the enables drop at that same edge.
- RESET: stays for RESET_CYCLES cycles after rst deasserts, then goes to HALT.
- HALT: halted=1. run=1 goes to F0; otherwise stays.
- F0: busB=PC, selop=PASS, mar_en=1.
- F1: wr_rdn=0, ir_en=1; PC <- PC+1 (busB=busC=PC, selop=INC, bank_wr_en=1).
- DEC: no strobes; branches on instruction[4:0].
- Class 00 (00ooo) goes to EXA: busB=A, busC=ACC, selop=ooo, shamt=0, enaf=1, bank_wr_en=1.
- Class 01 (01dss) goes to EXA with selop = d ? SHR : SHL and shamt=ss.
- 10000 LOAD:
  - LD0: busB=DPTR, selop=PASS, mar_en=1.
  - LD1: wr_rdn=0, mdr_alu_n=1, mdr_en=1.
  - LD2: mdr_alu_n=1, busC=ACC, bank_wr_en=1.
- 10001 STORE:
  - ST0 = LD0.
  - ST1: busB=ACC, selop=PASS, mdr_alu_n=0, mdr_en=1.
  - ST2: wr_rdn=1.
- Branch class:
  - 11000 JMP: always taken.
  - 11001 JZ, 11010 JN, 11011 JC, 11100 JP: taken only if the flag sampled in DEC is 1.
  - Taken goes to BR: busB=DPTR, selop=PASS, busC=PC, bank_wr_en=1. Not taken goes to F0.
- 11111 goes to HALT. All other codes are NOPs and go to F0.
- EXA, LD2, ST2 and BR return to F0. Instruction latency: ALU 4 cycles, LOAD/STORE 6.
- enaf is asserted only in EXA, so flags for branches reflect the last ALU/shift op.
- wr_rdn=1 only in ST2; it is never asserted in the same cycle as mdr_en with mdr_alu_n=1.
- run is ignored outside HALT.
- Encodings:
  - States: RESET=0, HALT=1, F0=2, F1=3, DEC=4, EXA=5, LD0..LD2=6..8, ST0..ST2=9..11, BR=12. Codes 13..15 go to RESET.
  - Registers: PC=000, DPTR=001, A=011, TEMP=100, ACC=111.
  - selop: PASS=000, INC=001, ADD=010, AND=011, XOR=100, OR=101, SHL=110, SHR=111.

Decomposition:
- control_pkg holds:
  - register address constants
  - selop codes
  - opcode constants
  - state localparams/encoding
- One sub-module, control_decoder: purely combinational, maps (next_state, instruction) to the control word. The FSM and reset counter live in control_sequencer.

Test Plan:
- rst=1 for 2 cycles then 0, RESET_CYCLES=2 -> ir_sclr=mar_sclr=1 for 2 cycles after release, then state_m=1, halted=1.
- run pulse, instruction=00100 (XOR) -> state_m 2,3,4,5 then 2; in EXA selop=100, busB=011, busC=111, enaf=1, bank_wr_en=1.
- instruction=01110 -> EXA with selop=111, shamt=10; instruction=10001 -> ST2 has wr_rdn=1 and mdr_en=0; ST1 has mdr_alu_n=0, busB=111.
- instruction=11001 with Z=0 -> DEC goes to F0 (no BR); with Z=1 -> BR: busB=001, busC=000, bank_wr_en=1.
- instruction=11111 -> HALT, halted=1, stays with run=0; run=1 -> F0 next cycle.
- rst=1 while in LD1 -> next edge state_m=0, mdr_en=0, wr_rdn=0; illegal state forced 13 -> RESET.
